issue_window_sched: RTL and testbench

- 8-entry issue-window scheduler that holds renamed micro-ops until both source operands are ready.
- Tracks per-entry relative age and selects the oldest ready entry using a 1-of-M oldest-first select, smaller age = older.
- Issues the selected entry to one functional unit through a registered valid/ready stage.
- Sits between dispatch (allocate side) and one execution unit; takes wakeup tags from result broadcast.

---
 rtl/issue_window_sched.sv | 160 ++++++++++++++++
 tb/tb_issue_window_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_window_sched.sv
// 8-entry issue window: holds renamed micro-ops until both sources are ready,
// then issues the oldest ready one through a registered valid/ready stage.
module issue_window_sched #(
  parameter int ENTRIES   = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [TAG_W-1:0]     alloc_src1_tag,
  input  logic                 alloc_src1_rdy,
  input  logic [TAG_W-1:0]     alloc_src2_tag,
  input  logic                 alloc_src2_rdy,
  input  logic [PAYLOAD_W-1:0] alloc_payload,
  input  logic                 wake0_valid,
  input  logic [TAG_W-1:0]     wake0_tag,
  input  logic                 wake1_valid,
  input  logic [TAG_W-1:0]     wake1_tag,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic [IDX_W-1:0]     iss_index,
  output logic [3:0]           count
);

  localparam logic [3:0] FULL_CNT = 4'(ENTRIES);

  logic [ENTRIES-1:0]                valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [ENTRIES-1:0][TAG_W-1:0]     tag1_q, tag1_d, tag2_q, tag2_d;
  logic [ENTRIES-1:0][IDX_W-1:0]     age_q, age_d;
  logic [ENTRIES-1:0][PAYLOAD_W-1:0] payload_q, payload_d;
  logic [3:0]                        count_q, count_d;
  logic                              iss_valid_q, iss_valid_d;
  logic [PAYLOAD_W-1:0]              iss_payload_q, iss_payload_d;
  logic [IDX_W-1:0]                  iss_index_q, iss_index_d;

  logic             grant_s, free_found_s, load_en_s, alloc_fire_s;
  logic [IDX_W-1:0] sel_idx_s, sel_age_s, free_idx_s, new_age_s;
  logic             new_rdy1_s, new_rdy2_s;

  function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                   input logic v0, input logic [TAG_W-1:0] t0,
                                   input logic v1, input logic [TAG_W-1:0] t1);
    return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
  endfunction

  assign alloc_ready  = (count_q < FULL_CNT) && !flush;
  assign alloc_fire_s = alloc_valid && alloc_ready;
  assign load_en_s    = grant_s && (!iss_valid_q || iss_ready);
  assign new_age_s    = IDX_W'(count_q - {3'b000, load_en_s});
  assign new_rdy1_s   = alloc_src1_rdy || tag_hit(alloc_src1_tag, wake0_valid, wake0_tag, wake1_valid, wake1_tag);
  assign new_rdy2_s   = alloc_src2_rdy || tag_hit(alloc_src2_tag, wake0_valid, wake0_tag, wake1_valid, wake1_tag);

  assign iss_valid   = iss_valid_q;
  assign iss_payload = iss_payload_q;
  assign iss_index   = iss_index_q;
  assign count       = count_q;

  // Oldest-ready select (strict compare keeps the lower index on a tie) and lowest free slot
  always_comb begin
    grant_s      = 1'b0;
    sel_idx_s    = '0;
    sel_age_s    = '0;
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      logic take_sel, take_free;
      take_sel     = valid_q[i] && rdy1_q[i] && rdy2_q[i] && (!grant_s || (age_q[i] < sel_age_s));
      sel_idx_s    = take_sel ? IDX_W'(i) : sel_idx_s;
      sel_age_s    = take_sel ? age_q[i] : sel_age_s;
      grant_s      = grant_s || take_sel;
      take_free    = !valid_q[i] && !free_found_s;
      free_idx_s   = take_free ? IDX_W'(i) : free_idx_s;
      free_found_s = free_found_s || take_free;
    end
  end

  // Next-state: wakeup, issue removal with age compaction, allocation, issue register, flush
  always_comb begin
    valid_d       = valid_q;
    rdy1_d        = rdy1_q;
    rdy2_d        = rdy2_q;
    tag1_d        = tag1_q;
    tag2_d        = tag2_q;
    age_d         = age_q;
    payload_d     = payload_q;
    count_d       = count_q;
    iss_valid_d   = iss_valid_q;
    iss_payload_d = iss_payload_q;
    iss_index_d   = iss_index_q;

    for (int i = 0; i < ENTRIES; i++) begin
      logic alloc_here, issued_here, older_gone;
      alloc_here   = alloc_fire_s && (free_idx_s == IDX_W'(i));
      issued_here  = load_en_s && (sel_idx_s == IDX_W'(i));
      older_gone   = load_en_s && valid_q[i] && (age_q[i] > sel_age_s);
      valid_d[i]   = alloc_here || (valid_q[i] && !issued_here);
      rdy1_d[i]    = alloc_here ? new_rdy1_s :
                     (rdy1_q[i] || (valid_q[i] && tag_hit(tag1_q[i], wake0_valid, wake0_tag, wake1_valid, wake1_tag)));
      rdy2_d[i]    = alloc_here ? new_rdy2_s :
                     (rdy2_q[i] || (valid_q[i] && tag_hit(tag2_q[i], wake0_valid, wake0_tag, wake1_valid, wake1_tag)));
      tag1_d[i]    = alloc_here ? alloc_src1_tag : tag1_q[i];
      tag2_d[i]    = alloc_here ? alloc_src2_tag : tag2_q[i];
      payload_d[i] = alloc_here ? alloc_payload : payload_q[i];
      age_d[i]     = alloc_here ? new_age_s : (older_gone ? age_q[i] - IDX_W'(1) : age_q[i]);
    end

    if (load_en_s) begin
      iss_valid_d   = 1'b1;
      iss_payload_d = payload_q[sel_idx_s];
      iss_index_d   = sel_idx_s;
    end else if (iss_ready) begin
      iss_valid_d = 1'b0;
    end else begin
      iss_valid_d = iss_valid_q;
    end

    if (flush) begin
      valid_d     = '0;
      count_d     = 4'd0;
      iss_valid_d = 1'b0;
    end else begin
      count_d = count_q + {3'b000, alloc_fire_s} - {3'b000, load_en_s};
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      rdy1_q        <= '0;
      rdy2_q        <= '0;
      tag1_q        <= '0;
      tag2_q        <= '0;
      age_q         <= '0;
      payload_q     <= '0;
      count_q       <= 4'd0;
      iss_valid_q   <= 1'b0;
      iss_payload_q <= '0;
      iss_index_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      rdy1_q        <= rdy1_d;
      rdy2_q        <= rdy2_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      age_q         <= age_d;
      payload_q     <= payload_d;
      count_q       <= count_d;
      iss_valid_q   <= iss_valid_d;
      iss_payload_q <= iss_payload_d;
      iss_index_q   <= iss_index_d;
    end
  end

endmodule

// File: tb/tb_issue_window_sched.sv
// Bench for issue_window_sched: directed test-plan scenarios with literal expectations,
// then random traffic compared every cycle against an allocation-ordered queue model.
module tb_issue_window_sched;

  logic        clk = 1'b0;
  logic        rst_n, flush, alloc_valid, alloc_ready;
  logic [5:0]  alloc_src1_tag, alloc_src2_tag, wake0_tag, wake1_tag;
  logic        alloc_src1_rdy, alloc_src2_rdy, wake0_valid, wake1_valid;
  logic [31:0] alloc_payload, iss_payload;
  logic        iss_valid, iss_ready;
  logic [2:0]  iss_index;
  logic [3:0]  count;

  int checks = 0;
  int failures = 0;

  issue_window_sched dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src1_rdy(alloc_src1_rdy),
    .alloc_src2_tag(alloc_src2_tag), .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_payload(alloc_payload),
    .wake0_valid(wake0_valid), .wake0_tag(wake0_tag),
    .wake1_valid(wake1_valid), .wake1_tag(wake1_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_payload(iss_payload), .iss_index(iss_index), .count(count)
  );

  always #5 clk = ~clk;

  // Model: entries plus a queue of entry indices in allocation order (front = oldest)
  bit          m_v[8], m_r1[8], m_r2[8];
  logic [5:0]  m_t1[8], m_t2[8];
  logic [31:0] m_p[8];
  int          m_order[$];
  bit          m_iv;
  logic [31:0] m_ipay;
  int          m_iidx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit woke(input logic [5:0] tag);
    return (wake0_valid && wake0_tag == tag) || (wake1_valid && wake1_tag == tag);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
    m_order.delete();
    m_iv = 1'b0;
  endtask

  task automatic model_edge();
    int sel, pos, free;
    bit load, afire;
    if (flush) begin
      model_reset();
      return;
    end
    sel = -1; pos = -1;
    for (int k = 0; k < m_order.size(); k++) begin
      if (m_r1[m_order[k]] && m_r2[m_order[k]]) begin
        sel = m_order[k]; pos = k; break;
      end
    end
    load  = (sel >= 0) && (!m_iv || iss_ready);
    afire = alloc_valid && (m_order.size() < 8);
    free = -1;
    for (int i = 0; i < 8; i++) if (!m_v[i] && free < 0) free = i;
    for (int i = 0; i < 8; i++) begin
      if (m_v[i] && woke(m_t1[i])) m_r1[i] = 1'b1;
      if (m_v[i] && woke(m_t2[i])) m_r2[i] = 1'b1;
    end
    if (load) begin
      m_iv = 1'b1; m_ipay = m_p[sel]; m_iidx = sel;
      m_v[sel] = 1'b0;
      m_order.delete(pos);
    end else if (m_iv && iss_ready) begin
      m_iv = 1'b0;
    end
    if (afire) begin
      m_v[free]  = 1'b1;
      m_t1[free] = alloc_src1_tag; m_t2[free] = alloc_src2_tag;
      m_r1[free] = alloc_src1_rdy || woke(alloc_src1_tag);
      m_r2[free] = alloc_src2_rdy || woke(alloc_src2_tag);
      m_p[free]  = alloc_payload;
      m_order.push_back(free);
    end
  endtask

  task automatic compare_model();
    chk("iss_valid", {31'b0, iss_valid}, {31'b0, m_iv});
    chk("count", {28'b0, count}, 32'(m_order.size()));
    chk("alloc_ready", {31'b0, alloc_ready}, {31'b0, (m_order.size() < 8) && !flush});
    if (m_iv) begin
      chk("iss_payload", iss_payload, m_ipay);
      chk("iss_index", {29'b0, iss_index}, 32'(m_iidx));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    flush = 1'b0; alloc_valid = 1'b0; alloc_payload = 32'h0;
    alloc_src1_tag = 6'd0; alloc_src1_rdy = 1'b0; alloc_src2_tag = 6'd0; alloc_src2_rdy = 1'b0;
    wake0_valid = 1'b0; wake0_tag = 6'd0; wake1_valid = 1'b0; wake1_tag = 6'd0;
  endtask

  task automatic drive_alloc(input logic [5:0] t1, input logic r1, input logic [31:0] pay);
    alloc_valid = 1'b1; alloc_src1_tag = t1; alloc_src1_rdy = r1;
    alloc_src2_tag = 6'd63; alloc_src2_rdy = 1'b1; alloc_payload = pay;
  endtask

  initial begin
    rst_n = 1'b0; iss_ready = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_iss_valid", {31'b0, iss_valid}, 32'd0);
    chk("reset_count", {28'b0, count}, 32'd0);
    chk("reset_alloc_ready", {31'b0, alloc_ready}, 32'd1);
    chk("reset_iss_payload", iss_payload, 32'd0);

    // Single ready op: visible two edges after it is presented
    drive_alloc(6'd1, 1'b1, 32'h11);
    step();
    chk("a_count", {28'b0, count}, 32'd1);
    alloc_valid = 1'b0;
    step();
    chk("a_iss_valid", {31'b0, iss_valid}, 32'd1);
    chk("a_iss_payload", iss_payload, 32'h11);
    chk("a_iss_index", {29'b0, iss_index}, 32'd0);
    chk("a_count_after", {28'b0, count}, 32'd0);
    step();

    // B waits on tag 5, younger C overtakes it; wake tag 5 then B issues
    drive_alloc(6'd5, 1'b0, 32'hB0);
    step();
    drive_alloc(6'd7, 1'b1, 32'hC0);
    step();
    alloc_valid = 1'b0;
    step();
    chk("bc_first_payload", iss_payload, 32'hC0);
    chk("bc_first_index", {29'b0, iss_index}, 32'd1);
    wake0_valid = 1'b1; wake0_tag = 6'd5;
    step();
    wake0_valid = 1'b0;
    step();
    chk("bc_second_payload", iss_payload, 32'hB0);
    chk("bc_second_index", {29'b0, iss_index}, 32'd0);
    step();

    // Fill all eight with a shared tag, wake once, drain in allocation order
    for (int i = 0; i < 8; i++) begin
      drive_alloc(6'd20, 1'b0, 32'h30 + 32'(i));
      step();
    end
    chk("full_count", {28'b0, count}, 32'd8);
    chk("full_alloc_ready", {31'b0, alloc_ready}, 32'd0);
    alloc_valid = 1'b0; wake0_valid = 1'b1; wake0_tag = 6'd20;
    step();
    wake0_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("drain_payload", iss_payload, 32'h30 + 32'(k));
      chk("drain_index", {29'b0, iss_index}, 32'(k));
      if (k == 0) chk("drain_alloc_ready", {31'b0, alloc_ready}, 32'd1);
    end
    step();

    // Stall: payload held, no entry removed; then back-to-back issue
    drive_alloc(6'd1, 1'b1, 32'h40);
    step();
    drive_alloc(6'd1, 1'b1, 32'h41); iss_ready = 1'b0;
    step();
    alloc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_payload", iss_payload, 32'h40);
      chk("stall_count", {28'b0, count}, 32'd1);
    end
    iss_ready = 1'b1;
    step();
    chk("b2b_payload", iss_payload, 32'h41);
    chk("b2b_valid", {31'b0, iss_valid}, 32'd1);
    step();
    chk("b2b_drained", {31'b0, iss_valid}, 32'd0);

    // Allocation coinciding with its wake tag
    drive_alloc(6'd33, 1'b0, 32'h50); wake1_valid = 1'b1; wake1_tag = 6'd33;
    step();
    alloc_valid = 1'b0; wake1_valid = 1'b0;
    step();
    chk("wake_alloc_valid", {31'b0, iss_valid}, 32'd1);
    chk("wake_alloc_payload", iss_payload, 32'h50);
    step();

    // Flush with five entries and a stalled issue register
    iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_alloc(6'd2, 1'b1, 32'h60 + 32'(i));
      step();
    end
    chk("pre_flush_count", {28'b0, count}, 32'd5);
    chk("pre_flush_valid", {31'b0, iss_valid}, 32'd1);
    alloc_valid = 1'b0; flush = 1'b1;
    step();
    chk("flush_count", {28'b0, count}, 32'd0);
    chk("flush_iss_valid", {31'b0, iss_valid}, 32'd0);
    flush = 1'b0;
    #1;
    chk("flush_alloc_ready", {31'b0, alloc_ready}, 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      alloc_valid    = ($urandom_range(0, 99) < 60);
      alloc_src1_tag = 6'($urandom_range(0, 7));
      alloc_src1_rdy = ($urandom_range(0, 99) < 40);
      alloc_src2_tag = 6'($urandom_range(0, 7));
      alloc_src2_rdy = ($urandom_range(0, 99) < 50);
      alloc_payload  = $urandom;
      wake0_valid    = ($urandom_range(0, 99) < 30);
      wake0_tag      = 6'($urandom_range(0, 7));
      wake1_valid    = ($urandom_range(0, 99) < 30);
      wake1_tag      = 6'($urandom_range(0, 7));
      iss_ready      = ($urandom_range(0, 99) < 65);
      flush          = ($urandom_range(0, 99) < 2);
      step();
    end

    // Reset during a stall clears the issue register immediately
    idle_inputs(); iss_ready = 1'b0;
    step();
    drive_alloc(6'd3, 1'b1, 32'h77);
    step();
    alloc_valid = 1'b0;
    step();
    chk("pre_reset_valid", {31'b0, iss_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'b0, iss_valid}, 32'd0);
    chk("async_reset_count", {28'b0, count}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; iss_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
